// File: rtl/prefetch_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
package prefetch_pkg;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] npc;
    logic        jump;
    logic        fence;
    logic [31:0] rdata;
    logic        ready;
  } prefetch_in_type;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] fpc;
    logic        stall;
  } prefetch_out_type;

  // Any low halfword whose opcode bits are not 2'b11 starts a compressed instruction.
  function automatic logic is_rvc(input logic [15:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/prefetch_buffer.sv
// Circular store of 16-bit halfwords: pushes 1 or 2 halfwords and pops 1 or 2 per cycle.
module prefetch_buffer #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        wr_en_i,
  input  logic        wr_two_i,
  input  logic [15:0] wr_lo_i,
  input  logic [15:0] wr_hi_i,
  input  logic        rd_en_i,
  input  logic        rd_two_i,
  output logic [15:0] hw0_o,
  output logic [15:0] hw1_o,
  output logic [AW:0] count_o
);

  logic [15:0]   store_q [DEPTH];
  logic [AW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [AW-1:0] rptr_inc, wptr_inc;
  logic [AW:0]   count_q, count_d;
  logic [AW:0]   wr_n, rd_n;

  assign wptr_inc = wptr_q + AW'(1);
  assign rptr_inc = rptr_q + AW'(1);

  always_comb begin
    wr_n = '0;
    rd_n = '0;
    if (wr_en_i) wr_n = wr_two_i ? (AW+1)'(2) : (AW+1)'(1);
    if (rd_en_i) rd_n = rd_two_i ? (AW+1)'(2) : (AW+1)'(1);
    // Pointers are AW bits wide so the additions wrap modulo DEPTH.
    wptr_d  = wptr_q + wr_n[AW-1:0];
    rptr_d  = rptr_q + rd_n[AW-1:0];
    count_d = count_q + wr_n - rd_n;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Contents need no reset: count gates every read.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      store_q[wptr_q] <= wr_lo_i;
      if (wr_two_i) store_q[wptr_inc] <= wr_hi_i;
    end
  end

  assign hw0_o   = store_q[rptr_q];
  assign hw1_o   = store_q[rptr_inc];
  assign count_o = count_q;

endmodule

// File: rtl/prefetch.sv
// Instruction prefetch: streams imem words into a halfword buffer and presents
// the next 16- or 32-bit instruction at pc, or a stall when it is incomplete.
module prefetch
  import prefetch_pkg::*;
#(
  parameter int          DEPTH      = 8,
  parameter logic [31:0] START_ADDR = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic [31:0] npc,
  input  logic        jump,
  input  logic        fence,
  input  logic [31:0] rdata,
  input  logic        ready,
  output logic [31:0] instr,
  output logic [31:0] fpc,
  output logic        stall
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);
  localparam logic [AW:0] TWO_C   = (AW+1)'(2);

  prefetch_in_type  in_s;
  prefetch_out_type out_s;

  logic [31:0] fpc_q, fpc_d;
  logic        skip_q, skip_d;
  logic        flush, accept, consume, size_two;
  logic [15:0] hw0, hw1;
  logic [AW:0] count, free;

  assign in_s = '{pc: pc, npc: npc, jump: jump, fence: fence, rdata: rdata, ready: ready};

  assign flush = in_s.jump | in_s.fence;
  assign free  = DEPTH_C - count;

  // imem handshake: ready marks rdata as the word at the fpc held this cycle;
  // fpc only advances on an accepted word, otherwise imem keeps re-returning it.
  assign accept = in_s.ready && !flush && (free >= TWO_C);

  always_comb begin
    out_s.instr = NOP;
    out_s.stall = 1'b1;
    out_s.fpc   = fpc_q;
    size_two    = 1'b0;
    if (count >= ONE_C && is_rvc(hw0)) begin
      out_s.instr = {16'h0000, hw0};
      out_s.stall = 1'b0;
    end else if (count >= TWO_C && !is_rvc(hw0)) begin
      out_s.instr = {hw1, hw0};
      out_s.stall = 1'b0;
      size_two    = 1'b1;
    end
  end

  // npc==pc means fetch_stage is holding, so nothing leaves the buffer.
  assign consume = !flush && !out_s.stall && (in_s.npc != in_s.pc);

  always_comb begin
    fpc_d  = fpc_q;
    skip_d = skip_q;
    if (flush) begin
      fpc_d  = {in_s.npc[31:2], 2'b00};
      skip_d = in_s.npc[1];
    end else if (accept) begin
      fpc_d  = fpc_q + 32'd4;
      skip_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fpc_q  <= START_ADDR;
      skip_q <= START_ADDR[1];
    end else begin
      fpc_q  <= fpc_d;
      skip_q <= skip_d;
    end
  end

  // A misaligned target drops the low halfword of its first word.
  prefetch_buffer #(.DEPTH(DEPTH)) u_buffer (
    .clk_i    (clk),
    .rst_ni   (rst),
    .flush_i  (flush),
    .wr_en_i  (accept),
    .wr_two_i (!skip_q),
    .wr_lo_i  (skip_q ? in_s.rdata[31:16] : in_s.rdata[15:0]),
    .wr_hi_i  (in_s.rdata[31:16]),
    .rd_en_i  (consume),
    .rd_two_i (size_two),
    .hw0_o    (hw0),
    .hw1_o    (hw1),
    .count_o  (count)
  );

  assign instr = out_s.instr;
  assign fpc   = out_s.fpc;
  assign stall = out_s.stall;

endmodule

// File: tb/tb_prefetch.sv
// Directed bench for prefetch: models imem and fetch_stage, checks presented instructions.
module tb_prefetch;
  import prefetch_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, npc, rdata, instr, fpc;
  logic        jump, fence, ready, stall;

  logic [31:0] mem [128];
  int checks = 0;
  int errors = 0;

  prefetch #(.DEPTH(DEPTH), .START_ADDR(32'h00000000)) dut (
    .clk   (clk),
    .rst   (rst),
    .pc    (pc),
    .npc   (npc),
    .jump  (jump),
    .fence (fence),
    .rdata (rdata),
    .ready (ready),
    .instr (instr),
    .fpc   (fpc),
    .stall (stall)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  function automatic logic [15:0] mem_hw(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[8:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  function automatic logic [31:0] exp_instr(input logic [31:0] a);
    logic [15:0] h0;
    h0 = mem_hw(a);
    if (h0[1:0] == 2'b11) return {mem_hw(a + 32'd2), h0};
    return {16'h0000, h0};
  endfunction

  task automatic fill_seq();
    for (int i = 0; i < 128; i++) mem[i] = 32'h00000093 | (32'(i) << 20);
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock; fetch_stage registers npc into pc, imem answers for fpc.
  task automatic cycle();
    @(posedge clk);
    #1;
    pc    = npc;
    rdata = mem[fpc[8:2]];
  endtask

  task automatic step(input bit hold);
    logic [31:0] e;
    e = exp_instr(pc);
    if (stall || hold) npc = pc;
    else npc = pc + ((e[1:0] == 2'b11) ? 32'd4 : 32'd2);
    cycle();
  endtask

  task automatic do_reset();
    rst   = 1'b0;
    jump  = 1'b0;
    fence = 1'b0;
    npc   = 32'h0;
    cycle();
    rst = 1'b1;
  endtask

  task automatic drive_stream(input int n);
    logic [31:0] lim;
    for (int i = 0; i < n; i++) begin
      lim = {pc[31:2], 2'b00} + 32'(2 * DEPTH);
      checks++;
      if (stall !== 1'b0) begin
        errors++;
        $display("FAIL stream_stall pc=%h: got %b expected 0", pc, stall);
      end
      checks++;
      if (instr !== exp_instr(pc)) begin
        errors++;
        $display("FAIL stream_instr pc=%h: got %h expected %h", pc, instr, exp_instr(pc));
      end
      checks++;
      if (fpc > lim) begin
        errors++;
        $display("FAIL fpc_ahead pc=%h: got %h expected <= %h", pc, fpc, lim);
      end
      step(1'b0);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    cycle();
    cycle();
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL reset_stall: got %b expected 1", stall); end
    checks++;
    if (instr !== 32'h00000013) begin errors++; $display("FAIL reset_instr: got %h expected 00000013", instr); end
    checks++;
    if (fpc !== 32'h0) begin errors++; $display("FAIL reset_fpc: got %h expected 00000000", fpc); end
  endtask

  task automatic test_sequential();
    fill_seq();
    do_reset();
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL seq_cycle0_stall: got %b expected 1", stall); end
    step(1'b0);
    checks++;
    if (stall !== 1'b0 || instr !== 32'h00000093) begin
      errors++;
      $display("FAIL seq_cycle1: got stall=%b instr=%h expected stall=0 instr=00000093", stall, instr);
    end
    drive_stream(8);
  endtask

  task automatic test_mixed();
    fill_seq();
    mem[0] = 32'h45010505;
    mem[1] = 32'h00A00093;
    do_reset();
    step(1'b0);
    checks++;
    if (instr !== 32'h00000505) begin errors++; $display("FAIL mixed_0: got %h expected 00000505", instr); end
    step(1'b0);
    checks++;
    if (instr !== 32'h00004501) begin errors++; $display("FAIL mixed_1: got %h expected 00004501", instr); end
    step(1'b0);
    checks++;
    if (instr !== 32'h00A00093) begin errors++; $display("FAIL mixed_2: got %h expected 00a00093", instr); end
  endtask

  task automatic test_jump();
    fill_seq();
    mem[64] = 32'h02930001;
    mem[65] = 32'h03130050;
    mem[66] = 32'h45010060;
    do_reset();
    step(1'b0);
    drive_stream(3);
    jump = 1'b1;
    npc  = 32'h00000102;
    cycle();
    jump = 1'b0;
    checks++;
    if (stall !== 1'b1 || fpc !== 32'h00000100) begin
      errors++;
      $display("FAIL jump_target: got stall=%b fpc=%h expected stall=1 fpc=00000100", stall, fpc);
    end
    step(1'b0);
    checks++;
    if (stall !== 1'b1 || fpc !== 32'h00000104) begin
      errors++;
      $display("FAIL jump_half: got stall=%b fpc=%h expected stall=1 fpc=00000104", stall, fpc);
    end
    step(1'b0);
    checks++;
    if (stall !== 1'b0 || instr !== 32'h00500293) begin
      errors++;
      $display("FAIL jump_split: got stall=%b instr=%h expected stall=0 instr=00500293", stall, instr);
    end
    step(1'b0);
    checks++;
    if (instr !== 32'h00600313) begin errors++; $display("FAIL jump_next: got %h expected 00600313", instr); end
    step(1'b0);
    checks++;
    if (instr !== 32'h00004501) begin errors++; $display("FAIL jump_rvc: got %h expected 00004501", instr); end
  endtask

  task automatic test_downstream_stall();
    fill_seq();
    do_reset();
    step(1'b0);
    drive_stream(3);
    for (int i = 0; i < 10; i++) step(1'b1);
    checks++;
    if (fpc !== pc + 32'd16) begin errors++; $display("FAIL hold_fpc_frozen: got %h expected %h", fpc, pc + 32'd16); end
    checks++;
    if (stall !== 1'b0 || instr !== 32'h00300093) begin
      errors++;
      $display("FAIL hold_instr: got stall=%b instr=%h expected stall=0 instr=00300093", stall, instr);
    end
    drive_stream(8);
  endtask

  task automatic test_jump_coincident();
    fill_seq();
    do_reset();
    step(1'b0);
    drive_stream(3);
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL coinc_pre_stall: got %b expected 0", stall); end
    jump = 1'b1;
    npc  = 32'h00000040;
    cycle();
    jump = 1'b0;
    checks++;
    if (stall !== 1'b1 || instr !== 32'h00000013 || fpc !== 32'h00000040) begin
      errors++;
      $display("FAIL coinc_flush: got stall=%b instr=%h fpc=%h expected stall=1 instr=00000013 fpc=00000040",
               stall, instr, fpc);
    end
    step(1'b0);
    checks++;
    if (stall !== 1'b0 || instr !== 32'h01000093 || fpc !== 32'h00000044) begin
      errors++;
      $display("FAIL coinc_refetch: got stall=%b instr=%h fpc=%h expected stall=0 instr=01000093 fpc=00000044",
               stall, instr, fpc);
    end
  endtask

  task automatic test_fence();
    fill_seq();
    do_reset();
    step(1'b0);
    drive_stream(2);
    fence = 1'b1;
    npc   = 32'h00000020;
    cycle();
    fence = 1'b0;
    checks++;
    if (stall !== 1'b1 || fpc !== 32'h00000020) begin
      errors++;
      $display("FAIL fence_flush: got stall=%b fpc=%h expected stall=1 fpc=00000020", stall, fpc);
    end
    step(1'b0);
    checks++;
    if (stall !== 1'b0 || instr !== 32'h00800093) begin
      errors++;
      $display("FAIL fence_refetch: got stall=%b instr=%h expected stall=0 instr=00800093", stall, instr);
    end
    jump  = 1'b1;
    fence = 1'b1;
    npc   = 32'h00000060;
    cycle();
    jump  = 1'b0;
    fence = 1'b0;
    checks++;
    if (stall !== 1'b1 || fpc !== 32'h00000060) begin
      errors++;
      $display("FAIL both_flush: got stall=%b fpc=%h expected stall=1 fpc=00000060", stall, fpc);
    end
    step(1'b0);
    checks++;
    if (stall !== 1'b0 || instr !== 32'h01800093) begin
      errors++;
      $display("FAIL both_refetch: got stall=%b instr=%h expected stall=0 instr=01800093", stall, instr);
    end
  endtask

  task automatic test_reset_mid();
    fill_seq();
    do_reset();
    step(1'b0);
    drive_stream(4);
    rst = 1'b0;
    npc = 32'h0;
    cycle();
    checks++;
    if (stall !== 1'b1 || instr !== 32'h00000013 || fpc !== 32'h0) begin
      errors++;
      $display("FAIL midreset: got stall=%b instr=%h fpc=%h expected stall=1 instr=00000013 fpc=00000000",
               stall, instr, fpc);
    end
    rst = 1'b1;
    step(1'b0);
    checks++;
    if (stall !== 1'b0 || instr !== 32'h00000093) begin
      errors++;
      $display("FAIL midreset_restart: got stall=%b instr=%h expected stall=0 instr=00000093", stall, instr);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst   = 1'b0;
    ready = 1'b1;
    jump  = 1'b0;
    fence = 1'b0;
    pc    = 32'h0;
    npc   = 32'h0;
    fill_seq();
    rdata = mem[0];

    test_reset();
    test_sequential();
    test_mixed();
    test_jump();
    test_downstream_stall();
    test_jump_coincident();
    test_fence();
    test_reset_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
